channel_serializer: RTL and testbench

//   Sink-side counterpart of convolve_reduce's master stream. Accepts one

---
 rtl/channel_serializer.sv | 115 +++++++++++
 tb/tb_channel_serializer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_serializer.sv
// channel_serializer
//   Accepts one CHANNELS-wide signed activation vector per slave handshake and
//   replays it as CHANNELS single-activation beats on the master stream,
//   channel 0 first, tagged with its channel index and a last flag.
//
// Ports
//   clock_i           clock, all state on posedge
//   reset_i           asynchronous active-low reset
//   slave_valid_i     input vector valid
//   slave_ready_o     input vector accepted when valid & ready
//   slave_data_i      packed vector, element [0] is emitted first
//   master_valid_o    output beat valid
//   master_ready_i    downstream accepts beat
//   master_data_o     activation of the current channel
//   master_channel_o  channel index of the current beat
//   master_last_o     high on the beat carrying channel CHANNELS-1
module channel_serializer #(
  parameter  int unsigned CHANNELS         = 3,
  parameter  int unsigned ACTIVATION_WIDTH = 8,
  localparam int unsigned INDEX_WIDTH      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                         clock_i,
  input  logic                                         reset_i,
  input  logic                                         slave_valid_i,
  output logic                                         slave_ready_o,
  input  logic [0:CHANNELS-1][ACTIVATION_WIDTH-1:0]    slave_data_i,
  output logic                                         master_valid_o,
  input  logic                                         master_ready_i,
  output logic signed [ACTIVATION_WIDTH-1:0]           master_data_o,
  output logic [INDEX_WIDTH-1:0]                       master_channel_o,
  output logic                                         master_last_o
);

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } state_e;

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(CHANNELS - 1);

  state_e                                      state_q, state_d;
  logic [0:CHANNELS-1][ACTIVATION_WIDTH-1:0]   buffer_q, buffer_d;
  logic [INDEX_WIDTH-1:0]                      index_q, index_d;

  logic loaded;
  logic at_last;
  logic slave_hs;
  logic master_hs;

  assign loaded  = (state_q == LOADED);
  assign at_last = (index_q == LAST_INDEX);

  // Master side is decoded purely from registers; the only combinational
  // path through the block is master_ready_i -> slave_ready_o, which lets a
  // new vector load on the same edge the last beat leaves.
  assign master_valid_o   = loaded;
  assign master_channel_o = index_q;
  assign master_last_o    = loaded && at_last;
  assign slave_ready_o    = !loaded || (master_ready_i && master_last_o);

  assign slave_hs  = slave_valid_i && slave_ready_o;
  assign master_hs = master_valid_o && master_ready_i;

  always_comb begin
    master_data_o = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (index_q == INDEX_WIDTH'(i)) begin
        master_data_o = buffer_q[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    buffer_d = buffer_q;
    index_d  = index_q;
    unique case (state_q)
      EMPTY: begin
        if (slave_hs) begin
          buffer_d = slave_data_i;
          index_d  = '0;
          state_d  = LOADED;
        end
      end
      LOADED: begin
        if (master_hs) begin
          if (at_last) begin
            index_d = '0;
            if (slave_hs) begin
              buffer_d = slave_data_i;
            end else begin
              state_d = EMPTY;
            end
          end else begin
            index_d = index_q + INDEX_WIDTH'(1);
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= EMPTY;
      buffer_q <= '0;
      index_q  <= '0;
    end else begin
      state_q  <= state_d;
      buffer_q <= buffer_d;
      index_q  <= index_d;
    end
  end

endmodule

// File: tb/tb_channel_serializer.sv
module tb_channel_serializer;

  localparam int unsigned AW = 8;

  typedef struct {
    logic [AW-1:0] data;
    logic [1:0]    chan;
    logic          last;
  } beat_t;

  logic                    clock_i = 1'b0;
  logic                    reset_i = 1'b0;
  logic                    slave_valid_i = 1'b0;
  logic                    slave_ready_o;
  logic [0:2][AW-1:0]      slave_data_i = '0;
  logic                    master_valid_o;
  logic                    master_ready_i = 1'b1;
  logic signed [AW-1:0]    master_data_o;
  logic [1:0]              master_channel_o;
  logic                    master_last_o;

  logic                    s1_valid = 1'b0;
  logic                    s1_ready;
  logic [0:0][AW-1:0]      s1_data = '0;
  logic                    m1_valid;
  logic                    m1_ready = 1'b1;
  logic signed [AW-1:0]    m1_data;
  logic [0:0]              m1_channel;
  logic                    m1_last;

  channel_serializer #(.CHANNELS(3), .ACTIVATION_WIDTH(AW)) u_dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .slave_valid_i    (slave_valid_i),
    .slave_ready_o    (slave_ready_o),
    .slave_data_i     (slave_data_i),
    .master_valid_o   (master_valid_o),
    .master_ready_i   (master_ready_i),
    .master_data_o    (master_data_o),
    .master_channel_o (master_channel_o),
    .master_last_o    (master_last_o)
  );

  channel_serializer #(.CHANNELS(1), .ACTIVATION_WIDTH(AW)) u_dut1 (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .slave_valid_i    (s1_valid),
    .slave_ready_o    (s1_ready),
    .slave_data_i     (s1_data),
    .master_valid_o   (m1_valid),
    .master_ready_i   (m1_ready),
    .master_data_o    (m1_data),
    .master_channel_o (m1_channel),
    .master_last_o    (m1_last)
  );

  always #5 clock_i = ~clock_i;

  int    checks = 0;
  int    errors = 0;
  beat_t sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  int vecs[6][3] = '{
    '{-2, -16, 32}, '{8, 34, -80}, '{-14, -52, 128},
    '{20, 70, -176}, '{-26, -88, 224}, '{32, 106, -272}
  };

  // Downstream ready: always 1 unless stall_mode picks random 0..10-cycle stalls.
  bit stall_mode = 0;
  int stall_cnt  = 0;
  always @(posedge clock_i) begin
    #1;
    if (!stall_mode) begin
      master_ready_i = 1'b1;
    end else if (stall_cnt > 0) begin
      master_ready_i = 1'b0;
      stall_cnt--;
    end else begin
      master_ready_i = 1'b1;
      if ($urandom_range(0, 2) == 0) stall_cnt = $urandom_range(0, 10);
    end
  end

  // Monitor / scoreboard: sampled on negedge when everything is settled.
  int            cyc = 0;
  int            beats = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;
  bit            prev_stall = 0;
  logic [AW-1:0] prev_data;
  logic [1:0]    prev_chan;
  logic          prev_last;
  always @(negedge clock_i) begin
    if (!reset_i) begin
      prev_stall = 0;
    end else begin
      cyc++;
      if (prev_stall) begin
        check_eq("stall_valid", {31'd0, master_valid_o}, 32'd1);
        check_eq("stall_data", {24'd0, master_data_o}, {24'd0, prev_data});
        check_eq("stall_chan", {30'd0, master_channel_o}, {30'd0, prev_chan});
        check_eq("stall_last", {31'd0, master_last_o}, {31'd0, prev_last});
      end
      if (slave_ready_o && master_valid_o)
        check_eq("ready_only_on_last", {31'd0, master_last_o && master_ready_i}, 32'd1);
      if (slave_valid_i && slave_ready_o) begin
        for (int c = 0; c < 3; c++) begin
          beat_t b;
          b.data = slave_data_i[c];
          b.chan = 2'(c);
          b.last = (c == 2);
          sb_q.push_back(b);
        end
      end
      if (master_valid_o && master_ready_i) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_beat", 32'd1, 32'd0);
        end else begin
          beat_t e;
          e = sb_q.pop_front();
          check_eq("beat_data", {24'd0, master_data_o}, {24'd0, e.data});
          check_eq("beat_chan", {30'd0, master_channel_o}, {30'd0, e.chan});
          check_eq("beat_last", {31'd0, master_last_o}, {31'd0, e.last});
        end
        if (beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
      end
      prev_stall = master_valid_o && !master_ready_i;
      prev_data  = master_data_o;
      prev_chan  = master_channel_o;
      prev_last  = master_last_o;
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic send_vec(input int v[3]);
    bit ok = 0;
    slave_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) slave_data_i[c] = AW'(v[c]);
    for (int n = 0; n < 300; n++) begin
      @(negedge clock_i);
      if (slave_ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
    @(posedge clock_i);
    #1;
    slave_valid_i = 1'b0;
  endtask

  task automatic drain(input int limit);
    bit ok = 0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clock_i);
      if (sb_q.size() == 0 && !master_valid_o) begin
        ok = 1;
        break;
      end
    end
    check_eq("drain_done", {31'd0, ok}, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, {31'd0, master_valid_o}, 32'd0);
    check_eq({tag, "_data"}, {24'd0, master_data_o}, 32'd0);
    check_eq({tag, "_chan"}, {30'd0, master_channel_o}, 32'd0);
    check_eq({tag, "_last"}, {31'd0, master_last_o}, 32'd0);
    check_eq({tag, "_sready"}, {31'd0, slave_ready_o}, 32'd1);
  endtask

  int v1[3];

  initial begin
    // Reset state
    repeat (3) @(posedge clock_i);
    #2;
    check_idle("rst_hold");
    check_eq("rst_dut1_valid", {31'd0, m1_valid}, 32'd0);
    @(posedge clock_i);
    #1;
    reset_i = 1'b1;
    @(negedge clock_i);
    check_idle("rst_release");
    @(posedge clock_i);
    #1;

    // Test 1: single vector, valid drops after the last beat
    send_vec(vecs[0]);
    repeat (3) @(negedge clock_i);
    @(negedge clock_i);
    check_eq("t1_valid_drop", {31'd0, master_valid_o}, 32'd0);
    drain(50);

    // Test 2 / 6: back-to-back vectors, no bubbles
    @(posedge clock_i);
    #1;
    beats = 0;
    for (int i = 0; i < 6; i++) send_vec(vecs[i]);
    drain(100);
    check_eq("t2_beats", 32'(beats), 32'd18);
    check_eq("t2_span", 32'(last_cyc - first_cyc), 32'd17);

    // Test 3: random downstream stalls
    @(posedge clock_i);
    #1;
    beats = 0;
    stall_mode = 1;
    for (int i = 0; i < 6; i++) send_vec(vecs[i]);
    drain(2000);
    check_eq("t3_beats", 32'(beats), 32'd18);
    stall_mode = 0;
    @(posedge clock_i);
    #1;

    // Test 4: async reset after channel 1 of a vector
    send_vec(vecs[1]);
    @(negedge clock_i);
    @(negedge clock_i);
    check_eq("t4_at_ch1", {30'd0, master_channel_o}, 32'd1);
    @(posedge clock_i);
    #2;
    reset_i = 1'b0;
    #1;
    check_idle("t4_async");
    sb_q.delete();
    @(posedge clock_i);
    #1;
    reset_i = 1'b1;
    @(posedge clock_i);
    #1;
    send_vec(vecs[2]);
    @(negedge clock_i);
    check_eq("t4_restart_ch", {30'd0, master_channel_o}, 32'd0);
    check_eq("t4_restart_valid", {31'd0, master_valid_o}, 32'd1);
    drain(50);

    // Test 5: CHANNELS=1 instance, one beat per cycle, all last
    v1 = '{5, -7, 127};
    for (int i = 0; i <= 3; i++) begin
      @(posedge clock_i);
      #1;
      if (i < 3) begin
        s1_valid   = 1'b1;
        s1_data[0] = AW'(v1[i]);
      end else begin
        s1_valid = 1'b0;
      end
      if (i > 0) begin
        @(negedge clock_i);
        check_eq("t5_valid", {31'd0, m1_valid}, 32'd1);
        check_eq("t5_data", {24'd0, m1_data}, {24'd0, AW'(v1[i-1])});
        check_eq("t5_chan", {31'd0, m1_channel}, 32'd0);
        check_eq("t5_last", {31'd0, m1_last}, 32'd1);
        check_eq("t5_sready", {31'd0, s1_ready}, 32'd1);
      end
    end
    @(posedge clock_i);
    #1;
    @(negedge clock_i);
    check_eq("t5_valid_drop", {31'd0, m1_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
